seq_fault_harness: RTL and testbench

Sequential fault-injection controller for re-sequentialised ISCAS89-class benchmarks such as the s832 family. It owns two copies of the benchmark's state register, a golden copy and a faulty copy. Both combinational next-state/output cones sit outside the block and are instantiated once per copy. The block runs one injection experiment per START: it flips one chosen state bit at a chosen cycle, then classifies the fault as detected, masked or latent. It sits between the campaign sequencer and the per-copy cones in the reliability-evaluation datapath.

---
 rtl/seq_fault_harness.sv | 200 ++++++++++++++++++++
 tb/tb_seq_fault_harness.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_fault_harness.sv
`default_nettype none
// ============================================================================
// Module      : seq_fault_harness
// Description : Sequential fault-injection controller. It holds a golden and
//               a faulty copy of a benchmark state register and runs one
//               experiment per START. Each experiment flips one state bit at
//               a chosen run cycle, then classifies the fault as DETECTED,
//               MASKED or LATENT.
// Ports       : CK/RST_N            clock, synchronous active-low reset
//               START               one-cycle request (IDLE only)
//               INJ_CYCLE/INJ_BIT   when and which bit to flip
//               MAX_CYCLES          run length limit
//               GOLD_NS/FAULT_NS    next state from each external cone
//               GOLD_PO/FAULT_PO    primary outputs from each external cone
//               GOLD_PS/FAULT_PS    present state driven into each cone
//               BUSY/DONE           status; DONE pulses once per experiment
//               DETECTED/MASKED/LATENT/DET_CYCLE  result, held to next START
// Revision    : 1.0 - initial release
// ============================================================================
module seq_fault_harness #(
    parameter int                 STATE_W     = 5,
    parameter int                 OUT_W       = 19,
    parameter int                 CYC_W       = 16,
    parameter logic [STATE_W-1:0] RESET_STATE = '0
) (
    input  logic                         CK,
    input  logic                         RST_N,
    input  logic                         START,
    input  logic [CYC_W-1:0]             INJ_CYCLE,
    input  logic [$clog2(STATE_W)-1:0]   INJ_BIT,
    input  logic [CYC_W-1:0]             MAX_CYCLES,
    input  logic [STATE_W-1:0]           GOLD_NS,
    input  logic [STATE_W-1:0]           FAULT_NS,
    input  logic [OUT_W-1:0]             GOLD_PO,
    input  logic [OUT_W-1:0]             FAULT_PO,
    output logic [STATE_W-1:0]           GOLD_PS,
    output logic [STATE_W-1:0]           FAULT_PS,
    output logic                         BUSY,
    output logic                         DONE,
    output logic                         DETECTED,
    output logic                         MASKED,
    output logic                         LATENT,
    output logic [CYC_W-1:0]             DET_CYCLE
);

    localparam int BIT_W = $clog2(STATE_W);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN_PRE  = 2'd1,
        S_RUN_POST = 2'd2,
        S_FINISH   = 2'd3
    } state_t;

    state_t             state_q,     state_d;
    logic [STATE_W-1:0] gold_ps_q,   gold_ps_d;
    logic [STATE_W-1:0] fault_ps_q,  fault_ps_d;
    logic [CYC_W-1:0]   cnt_q,       cnt_d;
    logic [CYC_W-1:0]   inj_cyc_q,   inj_cyc_d;
    logic [BIT_W-1:0]   inj_bit_q,   inj_bit_d;
    logic [CYC_W-1:0]   max_q,       max_d;
    logic               det_q,       det_d;
    logic               mask_q,      mask_d;
    logic               lat_q,       lat_d;
    logic [CYC_W-1:0]   det_cyc_q,   det_cyc_d;

    logic [STATE_W-1:0] flip_mask;
    logic               last_cycle;
    logic               po_mismatch;
    logic               ns_equal;

    // One-hot flip mask; an out-of-range bit index matches no position, so
    // the mask stays zero and the injection becomes a no-op.
    always_comb begin
        flip_mask = '0;
        for (int i = 0; i < STATE_W; i++) begin
            if (inj_bit_q == i[BIT_W-1:0]) begin
                flip_mask[i] = 1'b1;
            end
        end
    end

    assign last_cycle  = (cnt_q == (max_q - {{(CYC_W-1){1'b0}}, 1'b1}));
    assign po_mismatch = (GOLD_PO != FAULT_PO);
    // Compare the states the copies are about to load: a fault is flushed
    // when both copies leave this edge with the same state.
    assign ns_equal    = (GOLD_NS == FAULT_NS);

    always_comb begin
        state_d    = state_q;
        gold_ps_d  = gold_ps_q;
        fault_ps_d = fault_ps_q;
        cnt_d      = cnt_q;
        inj_cyc_d  = inj_cyc_q;
        inj_bit_d  = inj_bit_q;
        max_d      = max_q;
        det_d      = det_q;
        mask_d     = mask_q;
        lat_d      = lat_q;
        det_cyc_d  = det_cyc_q;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d    = S_RUN_PRE;
                    gold_ps_d  = RESET_STATE;
                    fault_ps_d = RESET_STATE;
                    cnt_d      = '0;
                    inj_cyc_d  = INJ_CYCLE;
                    inj_bit_d  = INJ_BIT;
                    max_d      = MAX_CYCLES;
                    det_d      = 1'b0;
                    mask_d     = 1'b0;
                    lat_d      = 1'b0;
                    det_cyc_d  = '0;
                end
            end

            S_RUN_PRE: begin
                gold_ps_d  = GOLD_NS;
                fault_ps_d = FAULT_NS;
                cnt_d      = cnt_q + 1'b1;
                // Timeout wins: if the run ends before or on the injection
                // cycle, the fault never took effect.
                if (last_cycle) begin
                    state_d = S_FINISH;
                    mask_d  = 1'b1;
                end else if (cnt_q == inj_cyc_q) begin
                    fault_ps_d = FAULT_NS ^ flip_mask;
                    state_d    = S_RUN_POST;
                end
            end

            S_RUN_POST: begin
                gold_ps_d  = GOLD_NS;
                fault_ps_d = FAULT_NS;
                cnt_d      = cnt_q + 1'b1;
                if (po_mismatch) begin
                    state_d   = S_FINISH;
                    det_d     = 1'b1;
                    det_cyc_d = cnt_q;
                end else if (ns_equal) begin
                    state_d = S_FINISH;
                    mask_d  = 1'b1;
                end else if (last_cycle) begin
                    // States still differ here, else the branch above fired.
                    state_d = S_FINISH;
                    lat_d   = 1'b1;
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CK) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            gold_ps_q  <= RESET_STATE;
            fault_ps_q <= RESET_STATE;
            cnt_q      <= '0;
            inj_cyc_q  <= '0;
            inj_bit_q  <= '0;
            max_q      <= '0;
            det_q      <= 1'b0;
            mask_q     <= 1'b0;
            lat_q      <= 1'b0;
            det_cyc_q  <= '0;
        end else begin
            state_q    <= state_d;
            gold_ps_q  <= gold_ps_d;
            fault_ps_q <= fault_ps_d;
            cnt_q      <= cnt_d;
            inj_cyc_q  <= inj_cyc_d;
            inj_bit_q  <= inj_bit_d;
            max_q      <= max_d;
            det_q      <= det_d;
            mask_q     <= mask_d;
            lat_q      <= lat_d;
            det_cyc_q  <= det_cyc_d;
        end
    end

    assign GOLD_PS   = gold_ps_q;
    assign FAULT_PS  = fault_ps_q;
    assign BUSY      = (state_q != S_IDLE);
    assign DONE      = (state_q == S_FINISH);
    assign DETECTED  = det_q;
    assign MASKED    = mask_q;
    assign LATENT    = lat_q;
    assign DET_CYCLE = det_cyc_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_fault_harness.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_fault_harness
// Description : Directed self-checking bench for seq_fault_harness. Models the
//               two benchmark cones with a few selectable behaviours.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_fault_harness;

    localparam int STATE_W = 5;
    localparam int OUT_W   = 19;
    localparam int CYC_W   = 16;

    logic               CK = 1'b0;
    logic               RST_N = 1'b0;
    logic               START = 1'b0;
    logic [CYC_W-1:0]   INJ_CYCLE = '0;
    logic [2:0]         INJ_BIT = '0;
    logic [CYC_W-1:0]   MAX_CYCLES = 16'd1;
    logic [STATE_W-1:0] GOLD_NS, FAULT_NS, GOLD_PS, FAULT_PS;
    logic [OUT_W-1:0]   GOLD_PO, FAULT_PO;
    logic               BUSY, DONE, DETECTED, MASKED, LATENT;
    logic [CYC_W-1:0]   DET_CYCLE;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done;
    int n_ticks;
    int mode = 0;

    seq_fault_harness #(
        .STATE_W(STATE_W), .OUT_W(OUT_W), .CYC_W(CYC_W), .RESET_STATE('0)
    ) dut (
        .CK(CK), .RST_N(RST_N), .START(START),
        .INJ_CYCLE(INJ_CYCLE), .INJ_BIT(INJ_BIT), .MAX_CYCLES(MAX_CYCLES),
        .GOLD_NS(GOLD_NS), .FAULT_NS(FAULT_NS),
        .GOLD_PO(GOLD_PO), .FAULT_PO(FAULT_PO),
        .GOLD_PS(GOLD_PS), .FAULT_PS(FAULT_PS),
        .BUSY(BUSY), .DONE(DONE), .DETECTED(DETECTED), .MASKED(MASKED),
        .LATENT(LATENT), .DET_CYCLE(DET_CYCLE)
    );

    always #5 CK = ~CK;

    // Cone models: 0 = counter with PO=PS, 1 = NS=0/PO=0, 2 = hold/PO=0
    always_comb begin
        GOLD_NS  = '0;
        FAULT_NS = '0;
        GOLD_PO  = '0;
        FAULT_PO = '0;
        case (mode)
            0: begin
                GOLD_NS  = GOLD_PS + 5'd1;
                FAULT_NS = FAULT_PS + 5'd1;
                GOLD_PO  = OUT_W'(GOLD_PS);
                FAULT_PO = OUT_W'(FAULT_PS);
            end
            2: begin
                GOLD_NS  = GOLD_PS;
                FAULT_NS = FAULT_PS;
            end
            default: ;
        endcase
    end

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input int m, input int ic, input int ib, input int mx);
        mode       = m;
        INJ_CYCLE  = CYC_W'(ic);
        INJ_BIT    = 3'(ib);
        MAX_CYCLES = CYC_W'(mx);
        START      = 1'b1;
        tick();
        START      = 1'b0;
    endtask

    initial begin
        // Reset state
        RST_N = 1'b0;
        tick(); tick();
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_flags", {DETECTED, MASKED, LATENT}, 0);
        check("rst_detcyc", DET_CYCLE, 0);
        check("rst_ps", {GOLD_PS, FAULT_PS}, 0);
        RST_N = 1'b1;
        tick();

        // 1: counter cone, flip bit 0 at cycle 3 -> detected at cnt 4
        start_run(0, 3, 0, 20);
        check("t1_busy", BUSY, 1);
        check("t1_ps0", GOLD_PS, 0);
        n_done = 0;
        for (int i = 0; i < 4; i++) begin tick(); n_done += int'(DONE); end
        check("t1_early_done", n_done, 0);
        check("t1_gold_ps", GOLD_PS, 4);
        check("t1_fault_ps", FAULT_PS, 5);
        tick();
        check("t1_done", DONE, 1);
        check("t1_flags", {DETECTED, MASKED, LATENT}, 3'b100);
        check("t1_detcyc", DET_CYCLE, 4);
        tick();
        check("t1_done_pulse", DONE, 0);
        check("t1_idle", BUSY, 0);
        check("t1_held", DETECTED, 1);

        // 2: NS=0 cones, flip bit 2 at cycle 5 -> masked on first post edge
        start_run(1, 5, 2, 20);
        check("t2_cleared", DETECTED, 0);
        for (int i = 0; i < 6; i++) tick();
        check("t2_fault_ps", FAULT_PS, 4);
        check("t2_no_done", DONE, 0);
        tick();
        check("t2_done", DONE, 1);
        check("t2_flags", {DETECTED, MASKED, LATENT}, 3'b010);
        tick();

        // 3: hold cones, flip bit 1 at cycle 2, MAX=10 -> latent
        start_run(2, 2, 1, 10);
        n_done = 0;
        for (int i = 0; i < 9; i++) begin tick(); n_done += int'(DONE); end
        check("t3_early_done", n_done, 0);
        check("t3_diverged", {GOLD_PS, FAULT_PS}, {5'd0, 5'd2});
        tick();
        check("t3_done", DONE, 1);
        check("t3_flags", {DETECTED, MASKED, LATENT}, 3'b001);
        check("t3_detcyc", DET_CYCLE, 0);
        tick();

        // 4: out-of-range bit index -> no divergence, masked
        start_run(0, 2, 7, 20);
        n_ticks = 0;
        n_done  = 0;
        for (int i = 0; i < 10 && n_done == 0; i++) begin
            tick();
            n_ticks++;
            n_done = int'(DONE);
            check("t4_ps_equal", FAULT_PS, GOLD_PS);
        end
        check("t4_done_at", n_ticks, 4);
        check("t4_flags", {DETECTED, MASKED, LATENT}, 3'b010);
        tick();

        // 5: reset mid RUN_POST abandons the experiment
        start_run(2, 1, 0, 50);
        for (int i = 0; i < 3; i++) tick();
        check("t5_pre_fault", FAULT_PS, 1);
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        check("t5_busy", BUSY, 0);
        check("t5_flags", {DONE, DETECTED, MASKED, LATENT}, 0);
        check("t5_ps", {GOLD_PS, FAULT_PS}, 0);
        n_done = 0;
        for (int i = 0; i < 6; i++) begin tick(); n_done += int'(DONE); end
        check("t5_no_done", n_done, 0);

        // 6: INJ_CYCLE >= MAX -> timeout in RUN_PRE; inputs changed after START
        start_run(0, 12, 0, 5);
        INJ_CYCLE  = 16'd0;
        MAX_CYCLES = 16'd100;
        for (int i = 0; i < 4; i++) tick();
        check("t6_no_done", DONE, 0);
        tick();
        check("t6_done", DONE, 1);
        check("t6_flags", {DETECTED, MASKED, LATENT}, 3'b010);
        check("t6_detcyc", DET_CYCLE, 0);
        check("t6_no_flip", FAULT_PS, GOLD_PS);
        tick();

        // 7: START held high through the run and the DONE cycle
        mode       = 0;
        INJ_CYCLE  = 16'd3;
        INJ_BIT    = 3'd0;
        MAX_CYCLES = 16'd20;
        START      = 1'b1;
        n_done     = 0;
        for (int i = 0; i < 7; i++) begin tick(); n_done += int'(DONE); end
        check("t7_one_done", n_done, 1);
        check("t7_idle_gap", BUSY, 0);
        tick();
        check("t7_restart", BUSY, 1);
        check("t7_restart_ps", GOLD_PS, 0);
        START = 1'b0;
        n_done = 0;
        for (int i = 0; i < 20 && n_done == 0; i++) begin tick(); n_done = int'(DONE); end
        check("t7_second_done", n_done, 1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
